// File: rtl/drone_pkg.sv
// Shared definitions for the grid drone game: state codes, menu modes and the obstacle map ROM.
// The optional gravity feature of simulador_drone is enabled with DRONE_GRAVIDADE_EN.
package drone_pkg;

   localparam int N_COLUNAS        = 16;
   localparam int N_LINHAS         = 4;
   localparam int VIDAS_MAX        = 3;
   localparam int GRAVIDADE_CICLOS = 1000;

   localparam logic [1:0] MODO_FACIL   = 2'd0;
   localparam logic [1:0] MODO_MEDIO   = 2'd1;
   localparam logic [1:0] MODO_DIFICIL = 2'd2;

   typedef enum logic [3:0] {
      INICIAL   = 4'h0,
      SEL_MODO  = 4'h1,
      SEL_VIDAS = 4'h2,
      SEL_MAPA  = 4'h3,
      PREPARA   = 4'h4,
      JOGANDO   = 4'h5,
      VENCEU    = 4'hA,
      PERDEU    = 4'hF
   } estado_t;

   // Row masks per [modo][mapa][coluna]; row 3 is never blocked so every map is winnable.
   localparam logic [3:0] MAPAS [0:2][0:1][0:15] = '{
      '{ '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h1, 4'h0, 4'h0},
         '{4'h0, 4'h2, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h1, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h2, 4'h0, 4'h0} },
      '{ '{4'h0, 4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h0},
         '{4'h0, 4'h4, 4'h1, 4'h0, 4'h3, 4'h0, 4'h6, 4'h0, 4'h5, 4'h0, 4'h3, 4'h0, 4'h6, 4'h0, 4'h5, 4'h0} },
      '{ '{4'h0, 4'h3, 4'h6, 4'h5, 4'h3, 4'h6, 4'h5, 4'h3, 4'h6, 4'h5, 4'h3, 4'h6, 4'h5, 4'h3, 4'h6, 4'h0},
         '{4'h0, 4'h7, 4'h0, 4'h7, 4'h0, 4'h7, 4'h0, 4'h7, 4'h0, 4'h7, 4'h0, 4'h7, 4'h0, 4'h7, 4'h0, 4'h0} }
   };

   function automatic logic [3:0] mascara(input logic [1:0] modo, input logic mapa,
                                          input logic [3:0] coluna);
      if (modo > MODO_DIFICIL) return 4'h0;
      return MAPAS[modo][mapa][coluna];
   endfunction

   function automatic logic comando_ativo(input logic [1:0] codigo);
      return (codigo == 2'b01) || (codigo == 2'b10);
   endfunction

endpackage

// File: rtl/hexa7seg.sv
// 4-bit value to active-high seven-segment glyph (bit0 = a ... bit6 = g), hex digits 0-F.
module hexa7seg (
   input  logic [3:0] valor,
   output logic [6:0] segmentos
);
   always_comb begin
      segmentos = 7'h00;
      case (valor)
         4'h0: segmentos = 7'h3F;
         4'h1: segmentos = 7'h06;
         4'h2: segmentos = 7'h5B;
         4'h3: segmentos = 7'h4F;
         4'h4: segmentos = 7'h66;
         4'h5: segmentos = 7'h6D;
         4'h6: segmentos = 7'h7D;
         4'h7: segmentos = 7'h07;
         4'h8: segmentos = 7'h7F;
         4'h9: segmentos = 7'h6F;
         4'hA: segmentos = 7'h77;
         4'hB: segmentos = 7'h7C;
         4'hC: segmentos = 7'h39;
         4'hD: segmentos = 7'h5E;
         4'hE: segmentos = 7'h79;
         4'hF: segmentos = 7'h71;
         default: segmentos = 7'h00;
      endcase
   end
endmodule

// File: rtl/simulador_drone.sv
// Grid drone game core: menu FSM, position/lives/collision datapath and input edge detectors.
// Define DRONE_GRAVIDADE_EN to make the drone fall one row per GRAVIDADE_CICLOS idle cycles.
module simulador_drone
   import drone_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [1:0] controle_vertical,
   input  logic [1:0] controle_horizontal,
   input  logic       confirma,
   output logic       venceu,
   output logic       perdeu,
   output logic [6:0] db_posicao_horizontal,
   output logic [6:0] db_posicao_vertical,
   output logic [6:0] db_obstaculos,
   output logic [6:0] db_estado,
   output logic [1:0] db_modo,
   output logic [6:0] colisao_counter_out,
   output logic [6:0] db_vidas
);
   localparam logic [3:0] COL_MAX    = 4'(N_COLUNAS - 1);
   localparam logic [1:0] LIN_MAX    = 2'(N_LINHAS - 1);
   localparam logic [1:0] VIDAS_TOPO = 2'(VIDAS_MAX);

   estado_t    estado, estado_prox;
   logic       iniciar_r, confirma_r, confirma_ant;
   logic [1:0] vert_r, vert_ant, hor_r, hor_ant;
   logic [3:0] coluna, colisoes;
   logic [1:0] linha, modo, vidas, vidas_sel;
   logic       mapa;

   logic       cmd_vert, cmd_hor, cmd_conf;
   logic       sobe, desce, frente, tras, queda;
   logic [3:0] col_alvo, mascara_alvo, mascara_atual;
   logic [1:0] lin_alvo, vidas_mais, vidas_menos;
   logic       mover, bloqueado, jogo_ativo;

   // Two-stage input capture: a command is the first cycle a registered code turns active.
   always_ff @(posedge clock) begin
      if (reset) begin
         iniciar_r    <= 1'b0;
         confirma_r   <= 1'b0;
         confirma_ant <= 1'b0;
         vert_r       <= 2'b00;
         vert_ant     <= 2'b00;
         hor_r        <= 2'b00;
         hor_ant      <= 2'b00;
      end else begin
         iniciar_r    <= iniciar;
         confirma_r   <= confirma;
         confirma_ant <= confirma_r;
         vert_r       <= controle_vertical;
         vert_ant     <= vert_r;
         hor_r        <= controle_horizontal;
         hor_ant      <= hor_r;
      end
   end

   assign cmd_vert = comando_ativo(vert_r) && !comando_ativo(vert_ant);
   assign cmd_hor  = comando_ativo(hor_r) && !comando_ativo(hor_ant);
   assign cmd_conf = confirma_r && !confirma_ant;
   assign sobe     = cmd_vert && (vert_r == 2'b01);
   assign desce    = cmd_vert && (vert_r == 2'b10);
   assign frente   = cmd_hor && (hor_r == 2'b01);
   assign tras     = cmd_hor && (hor_r == 2'b10);

`ifdef DRONE_GRAVIDADE_EN
   localparam int GW = $clog2(GRAVIDADE_CICLOS);
   logic [GW-1:0] grav_cnt;

   assign queda = (grav_cnt == GW'(GRAVIDADE_CICLOS - 1)) && !cmd_vert;

   always_ff @(posedge clock) begin
      if (reset || (estado != JOGANDO) || cmd_vert || queda) grav_cnt <= '0;
      else                                                   grav_cnt <= grav_cnt + 1'b1;
   end
`else
   assign queda = 1'b0;
`endif

   // Vertical movement (command or gravity) outranks horizontal in the same cycle.
   always_comb begin
      col_alvo = coluna;
      lin_alvo = linha;
      mover    = 1'b0;
      if (sobe) begin
         mover    = (linha != LIN_MAX);
         lin_alvo = linha + 2'd1;
      end else if (desce || queda) begin
         mover    = (linha != 2'd0);
         lin_alvo = linha - 2'd1;
      end else if (frente) begin
         mover    = (coluna != COL_MAX);
         col_alvo = coluna + 4'd1;
      end else if (tras) begin
         mover    = (coluna != 4'd0);
         col_alvo = coluna - 4'd1;
      end
   end

   assign mascara_alvo  = mascara(modo, mapa, col_alvo);
   assign mascara_atual = mascara(modo, mapa, coluna);
   assign bloqueado     = mascara_alvo[lin_alvo];
   assign jogo_ativo    = (estado == JOGANDO) && (vidas != 2'd0) && (coluna != COL_MAX);
   assign vidas_mais    = (vidas_sel == VIDAS_TOPO) ? 2'd1 : vidas_sel + 2'd1;
   assign vidas_menos   = (vidas_sel == 2'd1) ? VIDAS_TOPO : vidas_sel - 2'd1;

   always_ff @(posedge clock) begin
      if (reset) estado <= INICIAL;
      else       estado <= estado_prox;
   end

   always_comb begin
      estado_prox = estado;
      case (estado)
         INICIAL:   if (iniciar_r) estado_prox = SEL_MODO;
         SEL_MODO:  if (cmd_conf)  estado_prox = SEL_VIDAS;
         SEL_VIDAS: if (cmd_conf)  estado_prox = SEL_MAPA;
         SEL_MAPA:  if (cmd_conf)  estado_prox = PREPARA;
         PREPARA:   estado_prox = JOGANDO;
         JOGANDO: begin
            if (vidas == 2'd0)       estado_prox = PERDEU;
            else if (coluna == COL_MAX) estado_prox = VENCEU;
         end
         VENCEU, PERDEU: if (iniciar_r) estado_prox = SEL_MODO;
         default:   estado_prox = INICIAL;
      endcase
   end

   // vidas is the live count; vidas_sel remembers the menu choice across restarts.
   always_ff @(posedge clock) begin
      if (reset) begin
         coluna    <= 4'd0;
         linha     <= 2'd0;
         modo      <= MODO_FACIL;
         vidas     <= 2'd1;
         vidas_sel <= 2'd1;
         mapa      <= 1'b0;
         colisoes  <= 4'd0;
      end else begin
         case (estado)
            SEL_MODO: begin
               if (sobe)       modo <= (modo == MODO_DIFICIL) ? MODO_FACIL : modo + 2'd1;
               else if (desce) modo <= (modo == MODO_FACIL) ? MODO_DIFICIL : modo - 2'd1;
            end
            SEL_VIDAS: begin
               if (sobe) begin
                  vidas_sel <= vidas_mais;
                  vidas     <= vidas_mais;
               end else if (desce) begin
                  vidas_sel <= vidas_menos;
                  vidas     <= vidas_menos;
               end
            end
            SEL_MAPA: if (sobe || desce) mapa <= ~mapa;
            PREPARA: begin
               coluna   <= 4'd0;
               linha    <= 2'd0;
               colisoes <= 4'd0;
               vidas    <= vidas_sel;
            end
            JOGANDO: begin
               if (jogo_ativo && mover) begin
                  if (bloqueado) begin
                     vidas <= vidas - 2'd1;
                     if (colisoes != 4'hF) colisoes <= colisoes + 4'd1;
                  end else begin
                     coluna <= col_alvo;
                     linha  <= lin_alvo;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign venceu  = (estado == VENCEU);
   assign perdeu  = (estado == PERDEU);
   assign db_modo = modo;

   hexa7seg u_seg_col    (.valor(coluna),         .segmentos(db_posicao_horizontal));
   hexa7seg u_seg_lin    (.valor({2'b00, linha}), .segmentos(db_posicao_vertical));
   hexa7seg u_seg_obst   (.valor(mascara_atual),  .segmentos(db_obstaculos));
   hexa7seg u_seg_estado (.valor(estado),         .segmentos(db_estado));
   hexa7seg u_seg_colis  (.valor(colisoes),       .segmentos(colisao_counter_out));
   hexa7seg u_seg_vidas  (.valor({2'b00, vidas}), .segmentos(db_vidas));

endmodule

// File: tb/tb_simulador_drone.sv
// Scoreboard bench for simulador_drone: directed games plus random play against a rule-level model.
module tb_simulador_drone;

   localparam int K_UP = 1, K_DOWN = 2, K_FWD = 3, K_BACK = 4, K_CONF = 5,
                  K_INI = 6, K_BOTH = 7, K_BOTHD = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       iniciar = 1'b0;
   logic       confirma = 1'b0;
   logic [1:0] controle_vertical = 2'b00;
   logic [1:0] controle_horizontal = 2'b00;
   logic       venceu, perdeu;
   logic [6:0] db_posicao_horizontal, db_posicao_vertical, db_obstaculos, db_estado;
   logic [1:0] db_modo;
   logic [6:0] colisao_counter_out, db_vidas;

   simulador_drone dut (
      .clock                 (clock),
      .reset                 (reset),
      .iniciar               (iniciar),
      .controle_vertical     (controle_vertical),
      .controle_horizontal   (controle_horizontal),
      .confirma              (confirma),
      .venceu                (venceu),
      .perdeu                (perdeu),
      .db_posicao_horizontal (db_posicao_horizontal),
      .db_posicao_vertical   (db_posicao_vertical),
      .db_obstaculos         (db_obstaculos),
      .db_estado             (db_estado),
      .db_modo               (db_modo),
      .colisao_counter_out   (colisao_counter_out),
      .db_vidas              (db_vidas)
   );

   always #5 clock = ~clock;

   logic [6:0] seg_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic [3:0] mapas [0:2][0:1][0:15] = '{
      '{ '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h1, 4'h0, 4'h0},
         '{4'h0, 4'h2, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h1, 4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h2, 4'h0, 4'h0} },
      '{ '{4'h0, 4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h0},
         '{4'h0, 4'h4, 4'h1, 4'h0, 4'h3, 4'h0, 4'h6, 4'h0, 4'h5, 4'h0, 4'h3, 4'h0, 4'h6, 4'h0, 4'h5, 4'h0} },
      '{ '{4'h0, 4'h3, 4'h6, 4'h5, 4'h3, 4'h6, 4'h5, 4'h3, 4'h6, 4'h5, 4'h3, 4'h6, 4'h5, 4'h3, 4'h6, 4'h0},
         '{4'h0, 4'h7, 4'h0, 4'h7, 4'h0, 4'h7, 4'h0, 4'h7, 4'h0, 4'h7, 4'h0, 4'h7, 4'h0, 4'h7, 4'h0, 4'h0} }
   };

   // Game model: state codes as the displayed hex numbers.
   int m_est, m_col, m_lin, m_modo, m_vsel, m_vidas, m_mapa, m_colis;

   logic [45:0] exp_q[$];
   string       tag_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        obs = 1'b0;
   logic [1:0]  idle_v = 2'b00, idle_h = 2'b00;

   function automatic logic [6:0] seg(input int v);
      logic [3:0] n;
      n = 4'(v);
      return seg_tab[n];
   endfunction

   function automatic logic [45:0] modelo();
      logic [3:0] msk;
      msk = mapas[m_modo][m_mapa][m_col];
      return {(m_est == 10), (m_est == 15), seg(m_col), seg(m_lin), seg(int'(msk)),
              seg(m_est), 2'(m_modo), seg(m_colis), seg(m_vidas)};
   endfunction

   task automatic m_reset();
      m_est = 0; m_col = 0; m_lin = 0; m_modo = 0;
      m_vsel = 1; m_vidas = 1; m_mapa = 0; m_colis = 0;
   endtask

   task automatic m_acao(input int k);
      int dv, dh, tc, tl;
      logic [3:0] msk;
      dv = (k == K_UP || k == K_BOTH) ? 1 : (k == K_DOWN || k == K_BOTHD) ? -1 : 0;
      dh = (k == K_FWD || k == K_BOTH) ? 1 : (k == K_BACK || k == K_BOTHD) ? -1 : 0;
      case (m_est)
         0: if (k == K_INI) m_est = 1;
         1: begin
            if (dv == 1) m_modo = (m_modo + 1) % 3;
            else if (dv == -1) m_modo = (m_modo + 2) % 3;
            if (k == K_CONF) m_est = 2;
         end
         2: begin
            if (dv == 1) m_vsel = m_vsel % 3 + 1;
            else if (dv == -1) m_vsel = (m_vsel + 1) % 3 + 1;
            if (dv != 0) m_vidas = m_vsel;
            if (k == K_CONF) m_est = 3;
         end
         3: begin
            if (dv != 0) m_mapa = 1 - m_mapa;
            if (k == K_CONF) m_est = 4;
         end
         5: begin
            if (dv != 0) dh = 0;
            tc = m_col + dh;
            tl = m_lin + dv;
            if ((dv != 0 || dh != 0) && tc >= 0 && tc <= 15 && tl >= 0 && tl <= 3) begin
               msk = mapas[m_modo][m_mapa][tc];
               if (msk[tl[1:0]]) begin
                  m_vidas = m_vidas - 1;
                  if (m_colis < 15) m_colis = m_colis + 1;
               end else begin
                  m_col = tc;
                  m_lin = tl;
               end
            end
         end
         10, 15: if (k == K_INI) m_est = 1;
         default: ;
      endcase
   endtask

   task automatic m_assentar();
      if (m_est == 4) begin
         m_col = 0; m_lin = 0; m_colis = 0; m_vidas = m_vsel; m_est = 5;
      end else if (m_est == 5) begin
         if (m_vidas == 0) m_est = 15;
         else if (m_col == 15) m_est = 10;
      end
   endtask

   task automatic esperar(input string t);
      exp_q.push_back(modelo());
      tag_q.push_back(t);
   endtask

   task automatic soltar();
      idle_v = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      idle_h = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      controle_vertical   = idle_v;
      controle_horizontal = idle_h;
      confirma = 1'b0;
      iniciar  = 1'b0;
   endtask

   task automatic do_reset(input int n);
      @(posedge clock); #1;
      reset = 1'b1;
      soltar();
      repeat (n) @(posedge clock);
      #1 reset = 1'b0;
      m_reset();
      esperar("reset");
      obs = 1'b1;
      @(posedge clock); #1 obs = 1'b0;
   endtask

   // Checks the state one cycle after the edge is registered (unchanged), at the action cycle,
   // and again once win/lose/PREPARA follow-up transitions have settled.
   task automatic cmd(input int k, input string t);
      @(posedge clock); #1;
      case (k)
         K_UP:    controle_vertical = 2'b01;
         K_DOWN:  controle_vertical = 2'b10;
         K_FWD:   controle_horizontal = 2'b01;
         K_BACK:  controle_horizontal = 2'b10;
         K_CONF:  confirma = 1'b1;
         K_INI:   iniciar = 1'b1;
         K_BOTH:  begin controle_vertical = 2'b01; controle_horizontal = 2'b01; end
         K_BOTHD: begin controle_vertical = 2'b10; controle_horizontal = 2'b10; end
         default: ;
      endcase
      @(posedge clock); #1;
      esperar({t, "_pre"});
      obs = 1'b1;
      @(posedge clock); #1;
      m_acao(k);
      esperar(t);
      @(posedge clock); #1 obs = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1 soltar();
      repeat (4) @(posedge clock);
      #1;
      m_assentar();
      m_assentar();
      esperar({t, "_post"});
      obs = 1'b1;
      @(posedge clock); #1 obs = 1'b0;
   endtask

   always @(negedge clock) begin
      logic [45:0] act, e;
      string t;
      if (obs) begin
         act = {venceu, perdeu, db_posicao_horizontal, db_posicao_vertical, db_obstaculos,
                db_estado, db_modo, colisao_counter_out, db_vidas};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %h with no expected entry", act);
         end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (act !== e) begin
               errors++;
               $display("FAIL %s: got %h expected %h (venceu perdeu col lin obst estado modo colis vidas)",
                        t, act, e);
            end
         end
      end
   end

   initial begin
      #3000000;
      errors++;
      checks++;
      $display("FAIL watchdog: time limit reached before end of stimulus");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      int r, k;
      m_reset();
      do_reset(10);

      // Menu walk to medio / 3 lives / mapa 1, then moves including a collision.
      cmd(K_INI, "iniciar");
      cmd(K_UP, "modo_up");
      cmd(K_CONF, "conf_modo");
      cmd(K_UP, "vidas_up1");
      cmd(K_UP, "vidas_up2");
      cmd(K_CONF, "conf_vidas");
      cmd(K_UP, "mapa_up");
      cmd(K_CONF, "conf_mapa");
      cmd(K_FWD, "fwd_col1");
      cmd(K_UP, "up_row1");
      cmd(K_UP, "up_blocked");
      cmd(K_FWD, "fwd_col2");
      cmd(K_FWD, "fwd_col3");
      cmd(K_DOWN, "down_row0");
      cmd(K_DOWN, "down_edge");
      cmd(K_BACK, "back_col2");
      cmd(K_BOTH, "both_vert_wins");

      // Loss: dificil / mapa 1 / 3 lives, column 1 blocked at row 0.
      do_reset(3);
      cmd(K_INI, "l_iniciar");
      cmd(K_DOWN, "l_modo_down");
      cmd(K_CONF, "l_conf_modo");
      cmd(K_DOWN, "l_vidas_down");
      cmd(K_CONF, "l_conf_vidas");
      cmd(K_DOWN, "l_mapa");
      cmd(K_CONF, "l_conf_mapa");
      cmd(K_BACK, "l_back_edge");
      for (int i = 0; i < 3; i++) cmd(K_FWD, "l_collide");
      cmd(K_FWD, "l_ignored_in_perdeu");
      cmd(K_INI, "l_restart");

      // Win: facil / 1 life / mapa 0, climb to row 3 and run to the goal column.
      do_reset(3);
      cmd(K_INI, "w_iniciar");
      cmd(K_CONF, "w_conf_modo");
      cmd(K_CONF, "w_conf_vidas");
      cmd(K_CONF, "w_conf_mapa");
      for (int i = 0; i < 4; i++) cmd(K_UP, "w_up");
      for (int i = 0; i < 15; i++) cmd(K_FWD, "w_fwd");
      cmd(K_BACK, "w_ignored_in_venceu");
      cmd(K_INI, "w_restart");

      // Random play from the restarted menu.
      for (int i = 0; i < 140; i++) begin
         r = $urandom_range(0, 99);
         if (r < 25)      k = K_FWD;
         else if (r < 35) k = K_BACK;
         else if (r < 50) k = K_UP;
         else if (r < 60) k = K_DOWN;
         else if (r < 68) k = K_BOTH;
         else if (r < 73) k = K_BOTHD;
         else if (r < 88) k = K_CONF;
         else             k = K_INI;
         if (i == 70) do_reset(2);
         cmd(k, "rand");
      end

      repeat (3) @(posedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
